// File: rtl/adder4_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module  : adder4_accumulator_pkg
// Purpose : Shared command codes, FSM state encodings and the saturation
//           helper used by the 4-bit accumulator.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package adder4_accumulator_pkg;

  localparam int DATA_W = 4;

  // Command codes carried on in_cmd.
  typedef enum logic [1:0] {
    CMD_CLEAR = 2'b00,
    CMD_LOAD  = 2'b01,
    CMD_ADD   = 2'b10,
    CMD_READ  = 2'b11
  } cmd_e;

  // Control FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

  // Clamp value on signed overflow. Both operands share a sign when overflow
  // occurs, so the accumulator sign selects the rail.
  function automatic logic [DATA_W-1:0] sat_value(input logic sign);
    return sign ? 4'b1000 : 4'b0111;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder4_accumulator_full_adder.sv
`default_nettype none
// ============================================================================
// Module  : FullAdder4bit
// Purpose : 4-bit ripple-carry adder with carry-out and signed overflow.
// Ports   : a, b      in  4  operands
//           sum       out 4  a + b (mod 16)
//           carryout  out 1  unsigned carry out of bit 3
//           overflow  out 1  two's complement overflow
// Revision: 1.0 - initial release
// ============================================================================
module FullAdder4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] sum,
  output logic       carryout,
  output logic       overflow
);

  logic [4:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign carryout = carry[4];
  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign overflow = carry[3] ^ carry[4];

endmodule
`default_nettype wire

// File: rtl/adder4_accumulator.sv
`default_nettype none
// ============================================================================
// Module  : adder4_accumulator
// Purpose : 4-bit accumulator around one FullAdder4bit. Commands arrive on a
//           valid/ready channel; each result is presented on a valid/ready
//           output channel and held until taken.
// Ports   : clk, rst_n              clock, async active-low reset
//           in_valid/in_ready       command handshake
//           in_cmd[1:0], in_data[3:0] command and operand
//           out_valid/out_ready     result handshake
//           out_acc, out_carry, out_ovf  result of the op
//           sticky_ovf              OR of out_ovf since last CLEAR/LOAD
//           op_count[CNT_W-1:0]     ADDs since last CLEAR, saturating
// Revision: 1.0 - initial release
// ============================================================================
module adder4_accumulator
  import adder4_accumulator_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_cmd,
  input  logic [3:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_acc,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             sticky_ovf,
  output logic [CNT_W-1:0] op_count
);

  state_e     state;
  cmd_e       cmd_q;
  logic [3:0] operand_q;
  logic [3:0] acc;

  logic [3:0] add_sum;
  logic       add_carry;
  logic       add_ovf;
  logic [3:0] add_result;
  logic       accept;

  FullAdder4bit u_adder (
    .a        (acc),
    .b        (operand_q),
    .sum      (add_sum),
    .carryout (add_carry),
    .overflow (add_ovf)
  );

  // HOLD frees the slot in the same cycle the result is taken, allowing
  // back-to-back operation. Held low throughout reset.
  assign in_ready = rst_n & ((state == ST_IDLE) | ((state == ST_HOLD) & out_ready));
  assign accept   = in_valid & in_ready;

  always_comb begin
    add_result = add_sum;
    if ((SATURATE != 0) && add_ovf) begin
      add_result = sat_value(acc[3]);
    end
  end

  assign out_acc = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cmd_q      <= CMD_CLEAR;
      operand_q  <= '0;
      acc        <= '0;
      out_valid  <= 1'b0;
      out_carry  <= 1'b0;
      out_ovf    <= 1'b0;
      sticky_ovf <= 1'b0;
      op_count   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cmd_q     <= cmd_e'(in_cmd);
            operand_q <= in_data;
            state     <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          out_valid <= 1'b1;
          out_carry <= 1'b0;
          out_ovf   <= 1'b0;
          state     <= ST_HOLD;
          case (cmd_q)
            CMD_CLEAR: begin
              acc        <= '0;
              sticky_ovf <= 1'b0;
              op_count   <= '0;
            end
            CMD_LOAD: begin
              acc        <= operand_q;
              sticky_ovf <= 1'b0;
            end
            CMD_ADD: begin
              acc        <= add_result;
              out_carry  <= add_carry;
              out_ovf    <= add_ovf;
              sticky_ovf <= sticky_ovf | add_ovf;
              if (op_count != {CNT_W{1'b1}}) begin
                op_count <= op_count + CNT_W'(1);
              end
            end
            CMD_READ: begin
              acc <= acc;
            end
          endcase
        end

        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              cmd_q     <= cmd_e'(in_cmd);
              operand_q <= in_data;
              state     <= ST_EXEC;
            end else begin
              state <= ST_IDLE;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adder4_accumulator.sv
`default_nettype none
// ============================================================================
// Module  : tb_adder4_accumulator
// Purpose : Self-checking bench. Three accumulator variants (wrap, saturate,
//           2-bit counter) run the same command stream; a reference model
//           queues expected results at command acceptance and a monitor
//           compares them at each output handshake.
// Revision: 1.0 - initial release
// ============================================================================
module tb_adder4_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [1:0] in_cmd = 2'b00;
  logic [3:0] in_data = 4'h0;

  logic [2:0] rdy, vld, carry_o, ovf_o, sticky_o;
  logic [3:0] acc_o [3];
  logic [7:0] cnt_w, cnt_s;
  logic [1:0] cnt_c;

  always #5 clk = ~clk;

  adder4_accumulator #(.CNT_W(8), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_cmd(in_cmd), .in_data(in_data), .out_valid(vld[0]), .out_ready(out_ready),
    .out_acc(acc_o[0]), .out_carry(carry_o[0]), .out_ovf(ovf_o[0]),
    .sticky_ovf(sticky_o[0]), .op_count(cnt_w));

  adder4_accumulator #(.CNT_W(8), .SATURATE(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_cmd(in_cmd), .in_data(in_data), .out_valid(vld[1]), .out_ready(out_ready),
    .out_acc(acc_o[1]), .out_carry(carry_o[1]), .out_ovf(ovf_o[1]),
    .sticky_ovf(sticky_o[1]), .op_count(cnt_s));

  adder4_accumulator #(.CNT_W(2), .SATURATE(0)) dut_cnt (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_cmd(in_cmd), .in_data(in_data), .out_valid(vld[2]), .out_ready(out_ready),
    .out_acc(acc_o[2]), .out_carry(carry_o[2]), .out_ovf(ovf_o[2]),
    .sticky_ovf(sticky_o[2]), .op_count(cnt_c));

  typedef struct packed {
    logic [2:0][3:0] acc;
    logic [2:0]      carry;
    logic [2:0]      ovf;
    logic [2:0]      sticky;
    logic [2:0][7:0] cnt;
  } exp_t;

  exp_t sb[$];

  logic [3:0] m_acc [3];
  logic       m_sticky [3];
  int         m_cnt [3];
  int         cnt_max [3] = '{255, 255, 3};

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int hs_prev  = -100;
  int hs_last  = -100;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < 3; v++) begin
      m_acc[v] = 4'h0;
      m_sticky[v] = 1'b0;
      m_cnt[v] = 0;
    end
  endtask

  // Reference behaviour, computed arithmetically per variant.
  task automatic model_step(input logic [1:0] c, input logic [3:0] d);
    exp_t e;
    e = '0;
    for (int v = 0; v < 3; v++) begin
      logic [4:0] s;
      logic       o;
      s = {1'b0, m_acc[v]} + {1'b0, d};
      o = (m_acc[v][3] == d[3]) && (s[3] != m_acc[v][3]);
      case (c)
        2'b00: begin m_acc[v] = 4'h0; m_sticky[v] = 1'b0; m_cnt[v] = 0; end
        2'b01: begin m_acc[v] = d; m_sticky[v] = 1'b0; end
        2'b10: begin
          e.carry[v] = s[4];
          e.ovf[v]   = o;
          m_sticky[v] = m_sticky[v] | o;
          m_acc[v] = (v == 1 && o) ? (m_acc[v][3] ? 4'h8 : 4'h7) : s[3:0];
          if (m_cnt[v] < cnt_max[v]) m_cnt[v]++;
        end
        default: ;
      endcase
      e.acc[v]    = m_acc[v];
      e.sticky[v] = m_sticky[v];
      e.cnt[v]    = 8'(m_cnt[v]);
    end
    sb.push_back(e);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: samples just after the falling edge; a handshake seen
  // here completes at the following rising edge.
  always begin
    exp_t e;
    logic [7:0] gc;
    @(negedge clk);
    #1;
    if (rst_n) begin
      check("valid_align", {29'd0, vld}, vld[0] ? 32'd7 : 32'd0);
      if (vld[0] && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          for (int v = 0; v < 3; v++) begin
            gc = (v == 0) ? cnt_w : (v == 1) ? cnt_s : {6'd0, cnt_c};
            check($sformatf("acc[%0d]", v),    {28'd0, acc_o[v]},    {28'd0, e.acc[v]});
            check($sformatf("carry[%0d]", v),  {31'd0, carry_o[v]},  {31'd0, e.carry[v]});
            check($sformatf("ovf[%0d]", v),    {31'd0, ovf_o[v]},    {31'd0, e.ovf[v]});
            check($sformatf("sticky[%0d]", v), {31'd0, sticky_o[v]}, {31'd0, e.sticky[v]});
            check($sformatf("count[%0d]", v),  {24'd0, gc},          {24'd0, e.cnt[v]});
          end
          hs_prev = hs_last;
          hs_last = cyc;
        end
      end
    end
  end

  task automatic send(input logic [1:0] c, input logic [3:0] d);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_cmd   = c;
    in_data  = d;
    for (int i = 0; i < 50; i++) begin
      #1;
      ok = rdy[0];
      @(posedge clk);
      if (ok) break;
      @(negedge clk);
    end
    if (ok) model_step(c, d);
    else check("accept_timeout", 0, 1);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic op(input logic [1:0] c, input logic [3:0] d);
    send(c, d);
    idle();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1;
    check("rst_in_ready", {29'd0, rdy}, 0);
    check("rst_out_valid", {29'd0, vld}, 0);
    check("rst_acc", {28'd0, acc_o[0]}, 0);
    check("rst_count", {24'd0, cnt_w}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", {29'd0, rdy}, 3'b111);

    // Signed positive overflow: wrap vs clamp.
    op(2'b01, 4'b0101);
    op(2'b10, 4'b0011);
    drain();

    // Negative overflow, then LOAD clears sticky, then non-overflow carry.
    op(2'b01, 4'b1001);
    op(2'b10, 4'b1110);
    op(2'b01, 4'b1101);
    op(2'b10, 4'b1011);
    op(2'b11, 4'b0110);
    drain();

    // Back-to-back: second command waiting while the first is in HOLD.
    send(2'b01, 4'b1111);
    send(2'b10, 4'b1111);
    idle();
    drain();
    check("b2b_spacing", hs_last - hs_prev, 2);

    // Backpressure: result held, pending ADD not taken.
    out_ready = 1'b0;
    op(2'b01, 4'b0010);
    fork
      send(2'b10, 4'b0001);
      begin
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          #1;
          check("bp_in_ready", {29'd0, rdy}, 0);
          check("bp_out_valid", {31'd0, vld[0]}, 1);
          check("bp_acc_stable", {28'd0, acc_o[0]}, 32'h2);
          check("bp_not_consumed", sb.size(), 1);
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    idle();
    drain();

    // Counter saturation on the 2-bit instance.
    op(2'b00, 4'b1010);
    for (int i = 0; i < 5; i++) op(2'b10, 4'b0001);
    op(2'b00, 4'b0000);
    op(2'b11, 4'b1111);
    drain();

    // Reset while a result is held.
    out_ready = 1'b0;
    op(2'b10, 4'b0001);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {29'd0, vld}, 0);
    check("midrst_acc", {28'd0, acc_o[0]}, 0);
    check("midrst_count", {24'd0, cnt_w}, 0);
    check("midrst_in_ready", {29'd0, rdy}, 0);
    sb.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("postrst_no_valid", {29'd0, vld}, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
